// File: rtl/nibbler_core_p.sv
// nibbler_core_p
// Parametrised two-phase accumulator CPU (successor to the 4-bit Nibbler).
// Each instruction takes one fetch cycle and one execute cycle. The core
// reads its program from an external ROM, keeps a small internal data RAM,
// and has an output port whose ready/valid handshake can stall execution.
//
// Parameters
//   DATA_W  accumulator / immediate / RAM word width (1 <= DATA_W <= ADDR_W)
//   ADDR_W  program counter width, also the operand field width
//   RAM_AW  data RAM address bits (RAM_AW <= ADDR_W), depth 2**RAM_AW
//
// Ports
//   clk                rising-edge clock
//   reset              synchronous, active-high reset
//   direccion          program address (the PC)
//   prog               program word: [ADDR_W+3:ADDR_W] opcode, [ADDR_W-1:0] operand
//   fase               0 = fetch, 1 = execute
//   salida_acumulador  accumulator
//   notCarry           inverted carry flag
//   notZero            inverted zero flag
//   in_port            value loaded into the accumulator by IN
//   out_data           output port data (the accumulator)
//   out_valid          high throughout the execute phase of OUT
//   out_ready          consumer accepts out_data
module nibbler_core_p #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 12,
  parameter int RAM_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] direccion,
  input  logic [ADDR_W+3:0] prog,
  output logic              fase,
  output logic [DATA_W-1:0] salida_acumulador,
  output logic              notCarry,
  output logic              notZero,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int IR_W = ADDR_W + 4;

  typedef enum logic [3:0] {
    OP_JC    = 4'h0,
    OP_JNC   = 4'h1,
    OP_COMPI = 4'h2,
    OP_COMPM = 4'h3,
    OP_LIT   = 4'h4,
    OP_IN    = 4'h5,
    OP_LD    = 4'h6,
    OP_ST    = 4'h7,
    OP_JZ    = 4'h8,
    OP_JNZ   = 4'h9,
    OP_ADDI  = 4'hA,
    OP_ADDM  = 4'hB,
    OP_JMP   = 4'hC,
    OP_OUT   = 4'hD,
    OP_NORI  = 4'hE,
    OP_NORM  = 4'hF
  } opcode_t;

  typedef enum logic {
    PH_FETCH = 1'b0,
    PH_EXEC  = 1'b1
  } phase_t;

  // Architectural state
  logic [ADDR_W-1:0] pc;
  logic [IR_W-1:0]   ir;
  logic [DATA_W-1:0] acc;
  logic              c_flag;
  logic              z_flag;
  phase_t            phase;
  logic [DATA_W-1:0] ram [2**RAM_AW];

  // Decode of the instruction register
  opcode_t           op;
  logic [ADDR_W-1:0] operand;
  logic [RAM_AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rd;
  logic [DATA_W-1:0] x_val;

  assign op       = opcode_t'(ir[IR_W-1:ADDR_W]);
  assign operand  = ir[ADDR_W-1:0];
  assign ram_addr = operand[RAM_AW-1:0];
  assign ram_rd   = ram[ram_addr];

  // COMP, ADD and NOR come in I/M pairs whose opcodes differ only in bit 0:
  // the odd opcode takes the RAM word instead of the immediate.
  assign x_val = ir[ADDR_W] ? ram_rd : operand[DATA_W-1:0];

  // Datapath results, all on DATA_W+1 bits so the top bit is the carry.
  logic [DATA_W:0]   add_res;
  logic [DATA_W:0]   cmp_res;
  logic [DATA_W-1:0] nor_res;

  assign add_res = {1'b0, acc} + {1'b0, x_val};
  assign cmp_res = {1'b0, acc} + {1'b0, ~x_val} + {{DATA_W{1'b0}}, 1'b1};
  assign nor_res = ~(acc | x_val);

  logic jump_taken;
  logic out_stall;
  logic ram_we;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    jump_taken = 1'b0;
    unique case (op)
      OP_JC:   jump_taken = c_flag;
      OP_JNC:  jump_taken = ~c_flag;
      OP_JZ:   jump_taken = z_flag;
      OP_JNZ:  jump_taken = ~z_flag;
      OP_JMP:  jump_taken = 1'b1;
      default: jump_taken = 1'b0;
    endcase
  end

  assign out_stall = (phase == PH_EXEC) && (op == OP_OUT) && !out_ready;
  assign ram_we    = (phase == PH_EXEC) && (op == OP_ST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= '0;
      ir     <= '0;
      acc    <= '0;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
      phase  <= PH_FETCH;
    end else if (phase == PH_FETCH) begin
      ir    <= prog;
      pc    <= pc + ADDR_W'(1);
      phase <= PH_EXEC;
    end else if (!out_stall) begin
      phase <= PH_FETCH;
      if (jump_taken) pc <= operand;
      unique case (op)
        OP_COMPI, OP_COMPM: begin
          c_flag <= cmp_res[DATA_W];
          z_flag <= (acc == x_val);
        end
        OP_LIT: acc <= operand[DATA_W-1:0];
        OP_IN:  acc <= in_port;
        OP_LD:  acc <= ram_rd;
        OP_ADDI, OP_ADDM: begin
          acc    <= add_res[DATA_W-1:0];
          c_flag <= add_res[DATA_W];
          z_flag <= (add_res[DATA_W-1:0] == '0);
        end
        OP_NORI, OP_NORM: begin
          acc    <= nor_res;
          z_flag <= (nor_res == '0);
        end
        default: ;
      endcase
    end
  end

  // NOTE: the data RAM has no reset (contents survive reset); reset only
  // gates the write so a ST interrupted by reset leaves memory untouched.
  always_ff @(posedge clk) begin
    if (!reset && ram_we) ram[ram_addr] <= acc;
  end

  assign direccion         = pc;
  assign fase              = phase;
  assign salida_acumulador = acc;
  assign notCarry          = ~c_flag;
  assign notZero           = ~z_flag;
  assign out_data          = acc;
  assign out_valid         = (phase == PH_EXEC) && (op == OP_OUT);

endmodule

// File: tb/tb_nibbler_core_p.sv
// Directed testbench for nibbler_core_p. Three instances share one clock:
//   u_dut4 : DATA_W=4, ADDR_W=12  flag/ALU/jump sequence
//   u_dut8 : DATA_W=8, ADDR_W=12  RAM variants, OUT handshake, reset cases
//   u_dutw : DATA_W=4, ADDR_W=4   PC wrap
// Each instance is held in reset until its turn. Outputs are sampled 1 time
// unit after the rising edge.
module tb_nibbler_core_p;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] opd);
    return {op, opd};
  endfunction

  // ---------------- u_dut4 : DATA_W=4, ADDR_W=12 ----------------
  logic        rst4;
  logic [11:0] dir4;
  logic [15:0] prog4;
  logic        fase4, nc4, nz4, ov4;
  logic [3:0]  acc4, od4, in4;
  logic        ordy4;
  logic [15:0] rom4 [4096];
  assign prog4 = rom4[dir4];

  nibbler_core_p #(.DATA_W(4), .ADDR_W(12), .RAM_AW(4)) u_dut4 (
    .clk(clk), .reset(rst4), .direccion(dir4), .prog(prog4), .fase(fase4),
    .salida_acumulador(acc4), .notCarry(nc4), .notZero(nz4), .in_port(in4),
    .out_data(od4), .out_valid(ov4), .out_ready(ordy4)
  );

  // ---------------- u_dut8 : DATA_W=8, ADDR_W=12 ----------------
  logic        rst8;
  logic [11:0] dir8;
  logic [15:0] prog8;
  logic        fase8, nc8, nz8, ov8;
  logic [7:0]  acc8, od8, in8;
  logic        ordy8;
  logic [15:0] rom8 [4096];
  assign prog8 = rom8[dir8];

  nibbler_core_p #(.DATA_W(8), .ADDR_W(12), .RAM_AW(4)) u_dut8 (
    .clk(clk), .reset(rst8), .direccion(dir8), .prog(prog8), .fase(fase8),
    .salida_acumulador(acc8), .notCarry(nc8), .notZero(nz8), .in_port(in8),
    .out_data(od8), .out_valid(ov8), .out_ready(ordy8)
  );

  int xfers8 = 0;
  always @(posedge clk) if (!rst8 && ov8 && ordy8) xfers8++;

  // ---------------- u_dutw : DATA_W=4, ADDR_W=4 ----------------
  logic        rstw;
  logic [3:0]  dirw;
  logic [7:0]  progw;
  logic        fasew, ncw, nzw, ovw;
  logic [3:0]  accw, odw, inw;
  logic        ordyw;
  logic [7:0]  romw [16];
  assign progw = romw[dirw];

  nibbler_core_p #(.DATA_W(4), .ADDR_W(4), .RAM_AW(4)) u_dutw (
    .clk(clk), .reset(rstw), .direccion(dirw), .prog(progw), .fase(fasew),
    .salida_acumulador(accw), .notCarry(ncw), .notZero(nzw), .in_port(inw),
    .out_data(odw), .out_valid(ovw), .out_ready(ordyw)
  );

  // One instruction on u_dut4 followed by ACC / flag checks.
  task automatic exec4(input string tag, input logic [3:0] e_acc,
                       input logic e_nc, input logic e_nz);
    step_n(2);
    check({tag, "_acc"}, acc4, e_acc);
    check({tag, "_nc"},  nc4,  e_nc);
    check({tag, "_nz"},  nz4,  e_nz);
  endtask

  task automatic exec8(input string tag, input logic [7:0] e_acc,
                       input logic e_nc, input logic e_nz);
    step_n(2);
    check({tag, "_acc"}, acc8, e_acc);
    check({tag, "_nc"},  nc8,  e_nc);
    check({tag, "_nz"},  nz8,  e_nz);
  endtask

  initial begin
    rst4 = 1'b1; rst8 = 1'b1; rstw = 1'b1;
    in4 = 4'h9; in8 = 8'h00; inw = 4'h0;
    ordy4 = 1'b1; ordy8 = 1'b1; ordyw = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      rom4[i] = '0;
      rom8[i] = '0;
    end
    for (int i = 0; i < 16; i++) romw[i] = {4'h4, 4'(i)};

    // u_dut4 program
    rom4[12'h000] = ins(4'h4, 12'h000); // LIT 0
    rom4[12'h001] = ins(4'h4, 12'h001); // LIT 1
    rom4[12'h002] = ins(4'h4, 12'h000); // LIT 0
    rom4[12'h003] = ins(4'h4, 12'h00F); // LIT 15
    rom4[12'h004] = ins(4'hE, 12'h00F); // NORI 15
    rom4[12'h005] = ins(4'hA, 12'h001); // ADDI 1
    rom4[12'h006] = ins(4'h2, 12'h001); // COMPI 1
    rom4[12'h007] = ins(4'h4, 12'h00F); // LIT 15
    rom4[12'h008] = ins(4'hA, 12'h001); // ADDI 1
    rom4[12'h009] = ins(4'h0, 12'h020); // JC 0x020
    rom4[12'h020] = ins(4'h4, 12'h00F); // LIT 15
    rom4[12'h021] = ins(4'hA, 12'h001); // ADDI 1
    rom4[12'h022] = ins(4'h1, 12'h040); // JNC 0x040 (not taken)
    rom4[12'h023] = ins(4'h5, 12'h000); // IN
    rom4[12'h024] = ins(4'h2, 12'h009); // COMPI 9
    rom4[12'h025] = ins(4'h8, 12'h050); // JZ 0x050
    rom4[12'h050] = ins(4'h2, 12'h00A); // COMPI 10
    rom4[12'h051] = ins(4'h9, 12'h060); // JNZ 0x060
    rom4[12'h060] = ins(4'hC, 12'h060); // JMP 0x060

    // u_dut8 program
    rom8[12'h000] = ins(4'h4, 12'h0A5); // LIT 0xA5
    rom8[12'h001] = ins(4'h7, 12'h013); // ST 0x13 (aliases to 3)
    rom8[12'h002] = ins(4'h4, 12'h000); // LIT 0
    rom8[12'h003] = ins(4'h6, 12'h003); // LD 0x03
    rom8[12'h004] = ins(4'hB, 12'h003); // ADDM 0x03
    rom8[12'h005] = ins(4'hF, 12'h003); // NORM 0x03
    rom8[12'h006] = ins(4'h3, 12'h003); // COMPM 0x03
    rom8[12'h007] = ins(4'hD, 12'h000); // OUT
    rom8[12'h008] = ins(4'hD, 12'h000); // OUT

    // ---------------- reset state ----------------
    step_n(2);
    check("rst_dir",   dir4,  12'h000);
    check("rst_fase",  fase4, 1'b0);
    check("rst_acc",   acc4,  4'h0);
    check("rst_nc",    nc4,   1'b1);
    check("rst_nz",    nz4,   1'b1);
    check("rst_valid", ov4,   1'b0);

    // ---------------- u_dut4 sequence ----------------
    rst4 = 1'b0;
    step();
    check("fetch_fase", fase4, 1'b1);
    check("fetch_pc",   dir4,  12'h001);
    step();
    check("lit0_acc",  acc4,  4'h0);
    check("exec_fase", fase4, 1'b0);
    exec4("lit1",  4'h1, 1'b1, 1'b1);
    exec4("lit0b", 4'h0, 1'b1, 1'b1);
    exec4("lit15", 4'hF, 1'b1, 1'b1);
    exec4("nori",  4'h0, 1'b1, 1'b0);
    exec4("addi",  4'h1, 1'b1, 1'b1);
    exec4("compi", 4'h1, 1'b0, 1'b0);
    exec4("lit15b", 4'hF, 1'b0, 1'b0);
    exec4("addi_wrap", 4'h0, 1'b0, 1'b0);
    step_n(2);
    check("jc_taken_dir", dir4, 12'h020);
    exec4("lit15c", 4'hF, 1'b0, 1'b0);
    exec4("addi_c", 4'h0, 1'b0, 1'b0);
    step_n(2);
    check("jnc_fall_dir", dir4, 12'h023);
    exec4("in", 4'h9, 1'b0, 1'b0);
    exec4("compi_eq", 4'h9, 1'b0, 1'b0);
    step_n(2);
    check("jz_taken_dir", dir4, 12'h050);
    exec4("compi_lt", 4'h9, 1'b1, 1'b1);
    step_n(2);
    check("jnz_taken_dir", dir4, 12'h060);
    step();
    check("jmp_self_fetch", dir4, 12'h061);
    step();
    check("jmp_self_exec", dir4, 12'h060);
    step_n(2);
    check("jmp_self_loop", dir4, 12'h060);
    rst4 = 1'b1;

    // ---------------- u_dut8: RAM variants ----------------
    rst8 = 1'b0;
    exec8("m_lit",  8'hA5, 1'b1, 1'b1);
    exec8("m_st",   8'hA5, 1'b1, 1'b1);
    exec8("m_lit0", 8'h00, 1'b1, 1'b1);
    exec8("m_ld",   8'hA5, 1'b1, 1'b1);
    exec8("m_addm", 8'h4A, 1'b0, 1'b1);
    exec8("m_norm", 8'h10, 1'b0, 1'b1);
    exec8("m_compm", 8'h10, 1'b1, 1'b1);

    // ---------------- OUT handshake with stall ----------------
    ordy8 = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("out_valid_stall", ov8,   1'b1);
      check("out_data_stall",  od8,   8'h10);
      check("out_pc_hold",     dir8,  12'h008);
      step();
    end
    check("out_still_exec", fase8, 1'b1);
    ordy8 = 1'b1;
    check("out_valid_last", ov8, 1'b1);
    step();
    check("out_done_valid", ov8,    1'b0);
    check("out_done_fase",  fase8,  1'b0);
    check("out_done_dir",   dir8,   12'h008);
    check("out_xfers",      xfers8, 1);

    // ---------------- reset during stall ----------------
    ordy8 = 1'b0;
    step();
    check("out2_valid", ov8, 1'b1);
    step();
    check("out2_stall", ov8, 1'b1);
    rst8 = 1'b1;
    step();
    check("rst_stall_valid", ov8,    1'b0);
    check("rst_stall_dir",   dir8,   12'h000);
    check("rst_stall_fase",  fase8,  1'b0);
    check("rst_stall_acc",   acc8,   8'h00);
    check("rst_stall_nc",    nc8,    1'b1);
    check("rst_stall_xfers", xfers8, 1);

    // ---------------- reset mid-execute of ST ----------------
    rom8[12'h000] = ins(4'h4, 12'h03C); // LIT 0x3C
    rom8[12'h001] = ins(4'h7, 12'h003); // ST 0x03
    rst8 = 1'b0;
    exec8("st_lit", 8'h3C, 1'b1, 1'b1);
    step();
    check("st_in_exec", fase8, 1'b1);
    rst8 = 1'b1;
    step();
    rom8[12'h000] = ins(4'h6, 12'h003); // LD 0x03
    rst8 = 1'b0;
    step_n(2);
    check("st_aborted_ram", acc8, 8'hA5);
    rst8 = 1'b1;

    // ---------------- u_dutw: PC wrap ----------------
    rstw = 1'b0;
    step_n(30);
    check("wrap_pre_dir", dirw, 4'hF);
    check("wrap_pre_acc", accw, 4'hE);
    step_n(2);
    check("wrap_dir", dirw, 4'h0);
    check("wrap_acc", accw, 4'hF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
